// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
//   mul_state_t       - sequencing states of the shift-and-add multiplier
//   MUL_WIDTH_DEFAULT - default multiplier operand width
package cpu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } mul_state_t;

  localparam int unsigned MUL_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell.
//   a, b  - addend bits
//   c_in  - carry in
//   sum   - sum bit
//   c_out - carry out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder built from a chain of fulladder cells.
//   x, y  - N-bit addends
//   c_in  - carry into bit 0
//   sum   - N-bit sum
//   c_out - carry out of bit N-1
module ripple_adder #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  // carry[i] feeds bit i; carry[N] is the final carry out
  logic [N:0] carry;

  assign carry[0] = c_in;
  assign c_out    = carry[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    fulladder u_fa (
      .a     (x[i]),
      .b     (y[i]),
      .c_in  (carry[i]),
      .sum   (sum[i]),
      .c_out (carry[i+1])
    );
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier.
// Takes exactly WIDTH cycles per multiply; one partial product is accumulated per cycle
// through a 2*WIDTH ripple adder.
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - request a multiply (sampled only when idle)
//   a, b    - unsigned multiplicand / multiplier, sampled with start
//   busy    - high while calculating
//   done    - one-cycle pulse when product has just updated
//   product - 2*WIDTH result register, held until the next completion
module seq_multiplier
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  mul_state_t       state;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    count;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;
  // The product always fits in 2*WIDTH bits, so the final carry is never set.
  logic             unused_c_out;

  assign addend = mplier[0] ? mcand : '0;

  ripple_adder #(
    .N (PW)
  ) u_adder (
    .x     (acc),
    .y     (addend),
    .c_in  (1'b0),
    .sum   (acc_next),
    .c_out (unused_c_out)
  );

  assign busy = (state == CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // No early exit: latency is fixed at WIDTH cycles regardless of operands.
          if (count == LAST_COUNT) begin
            product <= acc_next;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
